parking_controller: RTL and testbench

Parametrised successor to the single-lane parking gate FSM. Manages one entrance lane with password entry, a retry limit with timed lockout, a timed gate-open window, and a saturating occupancy counter shared with an independent exit lane. Sits between the lane sensors/keypad and the gate actuator/indicator LEDs.

---
 rtl/parking_controller.sv | 115 +++++++++++
 tb/tb_parking_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller.sv
// Entrance-lane parking controller: password gate with retry lockout, timed gate
// window and a saturating occupancy counter shared with an independent exit lane.
module parking_controller #(
  parameter int                CAPACITY    = 100,
  parameter int                CNT_W       = 7,
  parameter int                PASS_W      = 4,
  parameter logic [PASS_W-1:0] PASSWORD    = 4'b1011,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCK_CYCLES = 16,
  parameter int                GATE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sensor_entrance,
  input  logic              sensor_exit,
  input  logic              pass_valid,
  input  logic [PASS_W-1:0] password,
  output logic              GREEN_LED,
  output logic              RED_LED,
  output logic              FULL,
  output logic              LOCKED,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int TMAX    = (LOCK_CYCLES > GATE_CYCLES) ? LOCK_CYCLES : GATE_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    WRONG_PASS = 3'd2,
    GATE_OPEN  = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               prev_ent_q, prev_exit_q;

  logic entry_rise, exit_rise, full, inc, dec;

  assign entry_rise = sensor_entrance & ~prev_ent_q;
  assign exit_rise  = sensor_exit & ~prev_exit_q;
  assign full       = (occ_q == CNT_W'(CAPACITY));
  assign dec        = exit_rise & (occ_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      tries_q     <= '0;
      occ_q       <= '0;
      prev_ent_q  <= 1'b0;
      prev_exit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tries_q     <= tries_d;
      occ_q       <= occ_d;
      prev_ent_q  <= sensor_entrance;
      prev_exit_q <= sensor_exit;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_rise && !full) state_d = WAIT_PASS;
      end
      WAIT_PASS, WRONG_PASS: begin
        if (pass_valid) begin
          if (password == PASSWORD) begin
            state_d = GATE_OPEN;
            timer_d = TIMER_W'(GATE_CYCLES - 1);
            tries_d = '0;
            inc     = 1'b1;
          end else if (int'(tries_q) + 1 == MAX_TRIES) begin
            state_d = LOCKOUT;
            timer_d = TIMER_W'(LOCK_CYCLES - 1);
            tries_d = '0;
          end else begin
            state_d = WRONG_PASS;
            tries_d = tries_q + TRY_W'(1);
          end
        end
      end
      GATE_OPEN, LOCKOUT: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous admission and departure cancel out; dec is already gated at zero.
  always_comb begin
    occ_d = occ_q;
    if (inc && !dec)      occ_d = occ_q + CNT_W'(1);
    else if (dec && !inc) occ_d = occ_q - CNT_W'(1);
  end

  assign GREEN_LED = (state_q == GATE_OPEN);
  assign RED_LED   = (state_q == WRONG_PASS) | (state_q == LOCKOUT);
  assign LOCKED    = (state_q == LOCKOUT);
  assign FULL      = full;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller: default instance plus a CAPACITY=2
// instance sharing the same stimulus for the full-lot scenario.
module tb_parking_controller;

  localparam logic [3:0] PW = 4'b1011;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic       pass_valid = 1'b0;
  logic [3:0] password = 4'b0;

  logic       green, red, full, locked;
  logic [6:0] occ;
  logic       green2, red2, full2, locked2;
  logic [6:0] occ2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parking_controller dut (
    .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance),
    .sensor_exit(sensor_exit), .pass_valid(pass_valid), .password(password),
    .GREEN_LED(green), .RED_LED(red), .FULL(full), .LOCKED(locked), .occupancy(occ)
  );

  parking_controller #(.CAPACITY(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance),
    .sensor_exit(sensor_exit), .pass_valid(pass_valid), .password(password),
    .GREEN_LED(green2), .RED_LED(red2), .FULL(full2), .LOCKED(locked2), .occupancy(occ2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit = 1'b0;
    pass_valid = 1'b0;
    password = 4'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic entry();
    sensor_entrance = 1'b1;
    tick();
    sensor_entrance = 1'b0;
    tick();
  endtask

  task automatic pass(input logic [3:0] p);
    pass_valid = 1'b1;
    password = p;
    tick();
    pass_valid = 1'b0;
    password = 4'b0;
  endtask

  task automatic admit();
    entry();
    pass(PW);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and a single correct entry
    do_reset();
    chk("rst_green", green, 0);
    chk("rst_red", red, 0);
    chk("rst_full", full, 0);
    chk("rst_locked", locked, 0);
    chk("rst_occ", occ, 0);
    entry();
    chk("t1_wait_green", green, 0);
    pass(PW);
    chk("t1_green_c1", green, 1);
    chk("t1_occ", occ, 1);
    chk("t1_red", red, 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("t1_green_c%0d", i), green, 1);
    end
    tick();
    chk("t1_green_off", green, 0);

    // 2: two wrong passwords then the right one
    do_reset();
    entry();
    pass(4'b0000);
    chk("t2_red_w1", red, 1);
    chk("t2_green_w1", green, 0);
    pass(4'b0001);
    chk("t2_red_w2", red, 1);
    chk("t2_locked_w2", locked, 0);
    pass(PW);
    chk("t2_green", green, 1);
    chk("t2_red_clr", red, 0);
    chk("t2_occ", occ, 1);
    repeat (4) tick();
    chk("t2_idle", green, 0);

    // 3: tries were cleared, so three fresh wrongs are needed to lock
    entry();
    pass(4'b0000);
    pass(4'b0010);
    chk("t3_nolock_2", locked, 0);
    pass(4'b0011);
    chk("t3_locked", locked, 1);
    chk("t3_red", red, 1);
    pass(PW);
    chk("t3_ignore_green", green, 0);
    chk("t3_ignore_locked", locked, 1);
    repeat (14) tick();
    chk("t3_locked_last", locked, 1);
    chk("t3_red_last", red, 1);
    tick();
    chk("t3_unlocked", locked, 0);
    chk("t3_red_off", red, 0);
    chk("t3_occ", occ, 1);

    // 4: CAPACITY=2 instance
    do_reset();
    admit();
    admit();
    chk("t4_occ2", occ2, 2);
    chk("t4_full", full2, 1);
    entry();
    pass(PW);
    chk("t4_blocked_green", green2, 0);
    chk("t4_blocked_occ", occ2, 2);
    repeat (4) tick();
    sensor_exit = 1'b1;
    tick();
    chk("t4_exit_occ", occ2, 1);
    chk("t4_not_full", full2, 0);
    sensor_exit = 1'b0;
    tick();
    entry();
    pass(PW);
    chk("t4_reentry_green", green2, 1);
    chk("t4_reentry_occ", occ2, 2);
    repeat (4) tick();

    // 5: exit at zero, then held exit at three
    do_reset();
    sensor_exit = 1'b1;
    tick();
    sensor_exit = 1'b0;
    tick();
    chk("t5_exit_at_zero", occ, 0);
    admit();
    admit();
    admit();
    chk("t5_occ3", occ, 3);
    sensor_exit = 1'b1;
    repeat (10) tick();
    chk("t5_held_exit", occ, 2);
    sensor_exit = 1'b0;
    tick();
    chk("t5_after_release", occ, 2);

    // 6: simultaneous admit/exit, then async reset mid-gate
    do_reset();
    admit();
    chk("t6_occ1", occ, 1);
    entry();
    pass_valid = 1'b1;
    password = PW;
    sensor_exit = 1'b1;
    tick();
    pass_valid = 1'b0;
    sensor_exit = 1'b0;
    chk("t6_simul_occ", occ, 1);
    chk("t6_simul_green", green, 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_arst_green", green, 0);
    chk("t6_arst_red", red, 0);
    chk("t6_arst_locked", locked, 0);
    chk("t6_arst_full", full, 0);
    chk("t6_arst_occ", occ, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
